// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU / M-extension unit.
package alu_pkg;

  localparam int WORD_SIZE = 32;

  // Base integer ops (md = 0)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // M-extension ops (md = 1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, HOLD} alu_state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle, XLEN cycles per divide.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_o,
  output logic            done_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [XLEN-1:0] rem_q, quo_q, dsr_q, rem_d;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic [XLEN:0]   shifted;
  logic            ge;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    ge      = shifted >= {1'b0, dsr_q};
    rem_d   = ge ? XLEN'(shifted - {1'b0, dsr_q}) : shifted[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dsr_q  <= divisor_i;
      cnt_q  <= CW'(XLEN);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= {quo_q[XLEN-2:0], ge};
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CW'(1));
    end
  end

  // last_o marks the cycle whose edge retires the final iteration
  assign last_o      = (cnt_q == CW'(1));
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/alu_md.sv
// EX-stage execute unit: single-cycle integer ALU plus multi-cycle MUL/DIV behind valid/ready.
module alu_md
  import alu_pkg::*;
#(
  parameter int XLEN = WORD_SIZE,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic            md,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_t        state_q;
  logic [XLEN-1:0]   alu_out_q;
  logic [2*XLEN-1:0] prod_q;
  logic [2:0]        f3_q;
  logic              neg_quo_q, neg_rem_q;

  logic              accept, div_start, div_last, div_done;
  logic [XLEN-1:0]   base_res, special_res, abs1, abs2, quo, rem;
  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN-1:0] mfull;
  logic              div_signed, r1_neg, r2_neg, div_special;

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign alu_out   = alu_out_q;

  always_comb begin
    base_res = '0;
    case (funct3)
      F3_ADD:  base_res = alt ? (r1 - r2) : (r1 + r2);
      F3_SLL:  base_res = r1 << r2[SHW-1:0];
      F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(r1) < $signed(r2)};
      F3_SLTU: base_res = {{(XLEN-1){1'b0}}, r1 < r2};
      F3_XOR:  base_res = r1 ^ r2;
      F3_SRL: begin
        if (alt) base_res = XLEN'($signed(r1) >>> r2[SHW-1:0]);
        else     base_res = r1 >> r2[SHW-1:0];
      end
      F3_OR:   base_res = r1 | r2;
      F3_AND:  base_res = r1 & r2;
      default: base_res = '0;
    endcase
  end

  // Sign-extend to XLEN+1 bits so one signed multiplier covers all four variants
  always_comb begin
    ma    = {(funct3 != F3_MULHU) & r1[XLEN-1], r1};
    mb    = {((funct3 == F3_MUL) || (funct3 == F3_MULH)) & r2[XLEN-1], r2};
    mfull = ma * mb;
  end

  always_comb begin
    div_signed  = !funct3[0];
    r1_neg      = div_signed & r1[XLEN-1];
    r2_neg      = div_signed & r2[XLEN-1];
    abs1        = r1_neg ? -r1 : r1;
    abs2        = r2_neg ? -r2 : r2;
    div_special = 1'b0;
    special_res = '0;
    if (r2 == '0) begin
      div_special = 1'b1;
      special_res = funct3[1] ? r1 : '1;
    end else if (div_signed && r1 == XMIN && r2 == '1) begin
      div_special = 1'b1;
      special_res = funct3[1] ? '0 : XMIN;
    end
  end

  assign div_start = accept && md && funct3[2] && !div_special;

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk        (CLK),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (abs1),
    .divisor_i  (abs2),
    .quotient_o (quo),
    .remainder_o(rem),
    .last_o     (div_last),
    .done_o     (div_done)
  );

  always_ff @(posedge CLK) begin
    if (!rst) begin
      state_q   <= IDLE;
      alu_out_q <= '0;
      prod_q    <= '0;
      f3_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      f3_q <= funct3;
      if (!md) begin
        alu_out_q <= base_res;
        state_q   <= HOLD;
      end else if (!funct3[2]) begin
        prod_q  <= mfull;
        state_q <= MUL;
      end else if (div_special) begin
        alu_out_q <= special_res;
        state_q   <= HOLD;
      end else begin
        neg_quo_q <= r1_neg ^ r2_neg;
        neg_rem_q <= r1_neg;
        state_q   <= DIV;
      end
    end else begin
      case (state_q)
        MUL: begin
          alu_out_q <= (f3_q == F3_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
          state_q   <= HOLD;
        end
        DIV: if (div_last) state_q <= FIX;
        FIX: if (div_done) begin
          if (f3_q[1]) alu_out_q <= neg_rem_q ? -rem : rem;
          else         alu_out_q <= neg_quo_q ? -quo : quo;
          state_q <= HOLD;
        end
        HOLD:    if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (XLEN=32).
module tb_alu_md;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, alt, md, out_valid, out_ready, busy;
  logic [2:0]  funct3;
  logic [31:0] r1, r2, alu_out;
  int          checks = 0;
  int          failures = 0;

  alu_md #(.XLEN(32)) dut (
    .CLK(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .alt(alt), .md(md), .r1(r1), .r2(r2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [2:0] f, input logic a,
                       input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1; md = m; funct3 = f; alt = a; r1 = x; r2 = y;
  endtask

  // Issue from IDLE, confirm the unit stalls for lat-1 cycles, then check the result.
  task automatic run_op(input string tag, input logic m, input logic [2:0] f,
                        input logic [31:0] x, input logic [31:0] y,
                        input int lat, input logic [31:0] exp);
    int bad = 0;
    drive(m, f, 1'b0, x, y);
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) bad++;
      tick();
    end
    if (lat > 1) chk({tag, "_stall"}, bad, 0);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk(tag, alu_out, exp);
    tick();
    chk({tag, "_retire"}, out_valid, 0);
  endtask

  logic [2:0]  bf  [10];
  logic        ba  [10];
  logic [31:0] bx  [10], by [10], be [10];

  initial begin
    int bad;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; md = 1'b0; alt = 1'b0;
    funct3 = 3'd0; r1 = '0; r2 = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Reset in the middle of a divide aborts it
    rst = 1'b1;
    drive(1'b1, 3'b101, 1'b0, 32'd100, 32'd7);
    tick();
    in_valid = 1'b0;
    chk("middiv_busy", busy, 1);
    chk("middiv_in_ready", in_ready, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    bad = 0;
    repeat (40) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    chk("abort_no_valid", bad, 0);

    // Back-to-back base ops at one per cycle
    out_ready = 1'b1;
    bf[0]=3'b000; ba[0]=0; bx[0]=32'd5;        by[0]=32'd3;        be[0]=32'd8;
    bf[1]=3'b000; ba[1]=1; bx[1]=32'd3;        by[1]=32'd5;        be[1]=32'hFFFFFFFE;
    bf[2]=3'b101; ba[2]=1; bx[2]=32'h80000000; by[2]=32'd4;        be[2]=32'hF8000000;
    bf[3]=3'b010; ba[3]=0; bx[3]=32'hFFFFFFFF; by[3]=32'd1;        be[3]=32'd1;
    bf[4]=3'b011; ba[4]=0; bx[4]=32'hFFFFFFFF; by[4]=32'd1;        be[4]=32'd0;
    bf[5]=3'b001; ba[5]=0; bx[5]=32'd1;        by[5]=32'h3F;       be[5]=32'h80000000;
    bf[6]=3'b101; ba[6]=0; bx[6]=32'h80000000; by[6]=32'd4;        be[6]=32'h08000000;
    bf[7]=3'b100; ba[7]=0; bx[7]=32'hF0F0F0F0; by[7]=32'hFF00FF00; be[7]=32'h0FF00FF0;
    bf[8]=3'b110; ba[8]=1; bx[8]=32'hF0F0F0F0; by[8]=32'hFF00FF00; be[8]=32'hFFF0FFF0;
    bf[9]=3'b111; ba[9]=0; bx[9]=32'hF0F0F0F0; by[9]=32'hFF00FF00; be[9]=32'hF000F000;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, bf[i], ba[i], bx[i], by[i]);
      #1 chk($sformatf("base%0d_in_ready", i), in_ready, 1);
      if (i > 0) begin
        chk($sformatf("base%0d_valid", i - 1), out_valid, 1);
        chk($sformatf("base%0d_result", i - 1), alu_out, be[i - 1]);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("base9_valid", out_valid, 1);
    chk("base9_result", alu_out, be[9]);
    tick();
    chk("base_idle", out_valid, 0);

    run_op("add_wrap", 1'b0, 3'b000, 32'hFFFFFFFF, 32'd1, 1, 32'd0);
    run_op("slt_pos_neg", 1'b0, 3'b010, 32'd1, 32'hFFFFFFFF, 1, 32'd0);

    run_op("mulh", 1'b1, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'h00000000);
    run_op("mulhu", 1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
    run_op("mulhsu", 1'b1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
    run_op("mul", 1'b1, 3'b000, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFEB);

    run_op("div_neg", 1'b1, 3'b100, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFD);
    run_op("rem_neg", 1'b1, 3'b110, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF);
    run_op("divu", 1'b1, 3'b101, 32'd100, 32'd7, 34, 32'd14);
    run_op("remu", 1'b1, 3'b111, 32'd100, 32'd7, 34, 32'd2);
    run_op("div_negdiv", 1'b1, 3'b100, 32'd7, 32'hFFFFFFFE, 34, 32'hFFFFFFFD);
    run_op("rem_negdiv", 1'b1, 3'b110, 32'd7, 32'hFFFFFFFE, 34, 32'd1);

    run_op("div_by0", 1'b1, 3'b100, 32'd123, 32'd0, 1, 32'hFFFFFFFF);
    run_op("rem_by0", 1'b1, 3'b110, 32'd123, 32'd0, 1, 32'd123);
    run_op("divu_by0", 1'b1, 3'b101, 32'd123, 32'd0, 1, 32'hFFFFFFFF);
    run_op("div_ovf", 1'b1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
    run_op("rem_ovf", 1'b1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

    // Backpressure: result held, new op waits for out_ready
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 32'd10, 32'd20);
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_result", alu_out, 32'd30);
    drive(1'b0, 3'b100, 1'b0, 32'd1, 32'd3);
    bad = 0;
    repeat (3) begin
      #1 if (in_ready !== 1'b0) bad++;
      tick();
      if (out_valid !== 1'b1 || alu_out !== 32'd30) bad++;
    end
    chk("bp_hold", bad, 0);
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_new_valid", out_valid, 1);
    chk("bp_new_result", alu_out, 32'd2);
    tick();
    chk("bp_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Next-generation execute unit for the pipelined RV core: parametrised-width integer ALU plus RV M-extension multiply/divide.
- Sits in the EX stage behind a valid/ready handshake, so multi-cycle ops stall the pipeline instead of assuming single-cycle completion.
- Adds SUB, SRA, signed SLT and MUL/DIV/REM, correctly decoded.

Parameters:
XLEN, 32, operand/result width; must be a power of 2, >= 8.
SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
CLK  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
in_valid  in  1  operation offered.
in_ready  out  1  unit can accept an operation this cycle.
funct3  in  3  RV funct3.
alt  in  1  funct7[5]: selects SUB / SRA.
md  in  1  funct7[0]: selects M-extension op.
r1  in  XLEN  operand 1 (rs1).
r2  in  XLEN  operand 2 (rs2 or immediate).
out_valid  out  1  result available.
out_ready  in  1  consumer takes result.
alu_out  out  XLEN  result.
busy  out  1  multi-cycle op in flight (states MUL, DIV, FIX).

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; out_valid=0; alu_out=0; busy=0; divider regs and counter cleared.
  - Reset mid-MUL/DIV aborts the op; no result is ever presented.
- FSM states: IDLE, MUL, DIV, FIX, HOLD.
- Handshake:
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - An op is accepted on a cycle where in_valid && in_ready; operands are captured that edge.
  - Only one op is in flight at a time.
- Output hold:
  - In HOLD, out_valid=1; alu_out is stable until out_ready.
  - In HOLD, out_ready && !in_valid -> IDLE. out_ready && in_valid -> accept the new op directly.
  - out_valid is 0 in all other states.
- Base ops (md=0): result registered on the accept edge -> HOLD. out_valid the cycle after accept; throughput 1/cycle with out_ready held high.
  - 000: ADD, or SUB when alt=1.
  - 001: SLL, shamt = r2[SHW-1:0].
  - 010: SLT, signed compare.
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL, or SRA (arithmetic) when alt=1.
  - 110: OR.
  - 111: AND.
  - alt is ignored for funct3 other than 000/101.
  - Arithmetic is modulo 2^XLEN. Compare results are zero-extended 0/1.
- Multiply (md=1, funct3 0-3):
  - Ops: MUL = low XLEN bits; MULH = s*s high; MULHSU = s*u high; MULHU = u*u high.
  - Accept -> MUL (product register) -> HOLD. out_valid 2 cycles after accept.
  - Full 2*XLEN product formed from sign-extended (XLEN+1)-bit operands.
- Divide (md=1, funct3 4-7):
  - Ops: DIV, DIVU, REM, REMU.
  - Special cases resolved on the accept edge -> HOLD, latency 1:
    - r2==0: quotient = all ones, remainder = r1.
    - Signed r1==MIN && r2==-1: quotient = MIN, remainder = 0.
  - Otherwise, on accept: load |r1|, |r2| (signed ops) or raw values; record result sign; counter=XLEN -> DIV.
  - DIV: one restoring iteration per cycle; counter decrements; leave when counter reaches 0 -> FIX.
  - FIX: negate quotient if operand signs differ; negate remainder if r1<0 (signed ops) -> HOLD.
  - out_valid at XLEN+2 cycles after accept (34 for XLEN=32).
- in_valid during busy is ignored: in_ready=0, no capture.
- Simultaneous out_ready and in_valid in HOLD: the old result retires and the new op is accepted on the same edge.

Decomposition:
- Shared package alu_pkg:
  - funct3 localparams (F3_ADD … F3_AND, F3_MUL … F3_REMU).
  - typedef enum alu_state_t {IDLE, MUL, DIV, FIX, HOLD}.
  - XLEN default tied to the core's WORD_SIZE.
- One sub-module: alu_div_iter.
  - Contains the restoring divider datapath: remainder/quotient shift regs, counter, done flag.
  - Takes start, dividend, divisor (unsigned magnitudes).
  - Returns quotient and remainder.
  - Sign handling and the FSM stay in alu_md.

Test Plan:
- Reset mid-DIV: issue DIVU 100/7, assert rst=0 at cycle 5 for 1 cycle -> out_valid never rises for that op; state IDLE, in_ready=1 next cycle.
- Base ops back-to-back, out_ready=1:
  - ADD 5+3 -> 8; SUB alt=1 3-5 -> 0xFFFFFFFE; SRA 0x80000000>>4 -> 0xF8000000; SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
  - One result per cycle, each valid 1 cycle after accept.
- Multiply:
  - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MUL 7*-3 -> 0xFFFFFFEB.
  - Each valid exactly 2 cycles after accept.
- Divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU -> 2.
  - Each valid exactly 34 cycles after accept; in_ready=0 and busy=1 throughout.
- Divide special cases:
  - DIV x/0 with x=123 -> 0xFFFFFFFF; REM x/0 -> 123.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - All 1-cycle latency.
- Backpressure: out_ready=0 for 3 cycles after a result -> alu_out and out_valid stable; a new op offered is not accepted until out_ready=1, then accepted that same cycle.
